// File: rtl/ibex_perf_counters.sv
// ibex_perf_counters
// Machine-mode performance counter CSRs for the CHERI-extended ibex core:
// mcycle, minstret, mhpmcounter3..3+NumHpmCounters-1 (low and high halves),
// their mhpmevent selectors and mcountinhibit.
//
// Ports:
//   clk_i, rst_ni      core clock, asynchronous active-low reset
//   csr_req_i          CSR access valid this cycle
//   csr_addr_i         12-bit CSR address
//   csr_op_i           READ / WRITE / SET / CLEAR
//   csr_wdata_i        CSR write operand
//   csr_rdata_o        combinational read data (pre-write value)
//   csr_hit_o          address belongs to this block
//   instr_ret_i        one instruction retired this cycle
//   events_i           per-cycle event strobes, selected by mhpmeventN
//   debug_stop_i       debug halt with stopcount; freezes every counter
module ibex_perf_counters #(
  parameter int NumHpmCounters = 8,
  parameter int CounterWidth   = 40,
  parameter int NumEvents      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 csr_req_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [1:0]           csr_op_i,
  input  logic [31:0]          csr_wdata_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_hit_o,
  input  logic                 instr_ret_i,
  input  logic [NumEvents-1:0] events_i,
  input  logic                 debug_stop_i
);

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  // Slots 0 (mcycle), 1 (time, never used) and 2 (minstret) precede the HPMs.
  localparam int NumCnt = NumHpmCounters + 3;

  // Address bits [11:5] of each 32-entry range.
  localparam logic [6:0] RangeCfg = 7'h19;  // 0x320 mcountinhibit / mhpmevent
  localparam logic [6:0] RangeLo  = 7'h58;  // 0xB00 counter low halves
  localparam logic [6:0] RangeHi  = 7'h5C;  // 0xB80 counter high halves

  localparam logic [CounterWidth-1:0] CntOne = CounterWidth'(1);

  function automatic logic [31:0] calc_inh_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i == 0) || (i == 2) || (i >= 3 && i < NumCnt);
    end
    return m;
  endfunction

  localparam logic [31:0] InhMask = calc_inh_mask();

  if (NumHpmCounters < 0 || NumHpmCounters > 29) begin : gen_bad_num_hpm
    $error("NumHpmCounters must be in 0..29");
  end
  if (CounterWidth < 33 || CounterWidth > 64) begin : gen_bad_width
    $error("CounterWidth must be in 33..64");
  end
  if (NumEvents < 1 || NumEvents > 32) begin : gen_bad_events
    $error("NumEvents must be in 1..32");
  end

  logic [CounterWidth-1:0] cnt [NumCnt];
  logic [NumEvents-1:0]    evt [NumCnt];   // only slots 3.. are used
  logic [31:0]             inhibit;

  csr_op_e                 op;
  logic [4:0]              idx;
  logic                    sel_cfg, sel_lo, sel_hi;
  logic                    hit, impl, we;
  logic [CounterWidth-1:0] sel_cnt;
  logic [NumEvents-1:0]    sel_evt;
  logic [31:0]             rdata, wval;
  logic [NumCnt-1:0]       inc;

  assign op      = csr_op_e'(csr_op_i);
  assign idx     = csr_addr_i[4:0];
  assign sel_cfg = csr_addr_i[11:5] == RangeCfg;
  assign sel_lo  = csr_addr_i[11:5] == RangeLo;
  assign sel_hi  = csr_addr_i[11:5] == RangeHi;
  // Index 1 (time) lives elsewhere, so it is not claimed in any range.
  assign hit     = csr_req_i && (sel_cfg || sel_lo || sel_hi) && (idx != 5'd1);
  assign impl    = (idx == 5'd0) || (idx == 5'd2) ||
                   (int'(idx) >= 3 && int'(idx) < NumCnt);
  assign we      = hit && (op != CSR_OP_READ);

  // Select the addressed slot with a loop so an unimplemented index never
  // indexes past the arrays.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sel_cnt = '0;
    sel_evt = '0;
    for (int i = 0; i < NumCnt; i++) begin
      if (int'(idx) == i) begin
        sel_cnt = cnt[i];
        sel_evt = evt[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (hit && impl) begin
      if (sel_cfg) begin
        if (idx == 5'd0)         rdata = inhibit;
        else if (int'(idx) >= 3) rdata = 32'(sel_evt);
      end else if (sel_lo) begin
        rdata = sel_cnt[31:0];
      end else begin
        rdata = 32'(sel_cnt[CounterWidth-1:32]);
      end
    end
  end

  assign csr_rdata_o = rdata;
  assign csr_hit_o   = hit;

  always_comb begin
    unique case (op)
      CSR_OP_WRITE: wval = csr_wdata_i;
      CSR_OP_SET:   wval = rdata | csr_wdata_i;
      CSR_OP_CLEAR: wval = rdata & ~csr_wdata_i;
      default:      wval = rdata;
    endcase
  end

  // Increment strobes use the current (pre-write) inhibit register.
  always_comb begin
    inc = '0;
    for (int i = 0; i < NumCnt; i++) begin
      if (!inhibit[i] && !debug_stop_i) begin
        if (i == 0)      inc[i] = 1'b1;
        else if (i == 2) inc[i] = instr_ret_i;
        else if (i >= 3) inc[i] = |(evt[i] & events_i);
      end
    end
  end

  // A CSR write to either half of a counter takes precedence over, and
  // suppresses, that cycle's increment of the whole counter.
  // NOTE: counter and selector arrays are small register banks, not RAM, so
  // they are cleared by the asynchronous reset like any other state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inhibit <= '0;
      for (int i = 0; i < NumCnt; i++) begin
        cnt[i] <= '0;
        evt[i] <= '0;
      end
    end else begin
      // NOTE: sequential state is assigned with <= so every register samples
      // the pre-edge values regardless of statement order.
      if (we && sel_cfg && idx == 5'd0) inhibit <= wval & InhMask;
      for (int i = 0; i < NumCnt; i++) begin
        if (we && sel_cfg && i >= 3 && int'(idx) == i) begin
          evt[i] <= wval[NumEvents-1:0];
        end
        if (we && sel_lo && i != 1 && int'(idx) == i) begin
          cnt[i][31:0] <= wval;
        end else if (we && sel_hi && i != 1 && int'(idx) == i) begin
          cnt[i][CounterWidth-1:32] <= wval[CounterWidth-33:0];
        end else if (inc[i]) begin
          cnt[i] <= cnt[i] + CntOne;
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_perf_counters.sv
module tb_ibex_perf_counters;

  localparam int NumHpmCounters = 8;
  localparam int CounterWidth   = 40;
  localparam int NumEvents      = 16;

  localparam logic [1:0] OP_R = 2'd0;
  localparam logic [1:0] OP_W = 2'd1;
  localparam logic [1:0] OP_S = 2'd2;
  localparam logic [1:0] OP_C = 2'd3;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 csr_req = 1'b0;
  logic [11:0]          csr_addr = '0;
  logic [1:0]           csr_op = OP_R;
  logic [31:0]          csr_wdata = '0;
  logic [31:0]          csr_rdata;
  logic                 csr_hit;
  logic                 instr_ret = 1'b0;
  logic [NumEvents-1:0] events = '0;
  logic                 debug_stop = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] rd;
    logic        chk_rd;
    logic        hit;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        hit;
  } vec_t;

  ibex_perf_counters #(
    .NumHpmCounters(NumHpmCounters),
    .CounterWidth  (CounterWidth),
    .NumEvents     (NumEvents)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .csr_req_i   (csr_req),
    .csr_addr_i  (csr_addr),
    .csr_op_i    (csr_op),
    .csr_wdata_i (csr_wdata),
    .csr_rdata_o (csr_rdata),
    .csr_hit_o   (csr_hit),
    .instr_ret_i (instr_ret),
    .events_i    (events),
    .debug_stop_i(debug_stop)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One CSR access: driven on the falling edge, output sampled 1 time unit
  // later, write commits on the following rising edge.
  task automatic csr_access(input string name, input logic [1:0] op, input logic [11:0] addr,
                            input logic [31:0] wdata, input logic chk_rd,
                            input logic [31:0] exp_rd, input logic exp_hit);
    exp_t e;
    @(negedge clk_i);
    csr_req   = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wdata;
    sb_q.push_back('{rd: exp_rd, chk_rd: chk_rd, hit: exp_hit, name: name});
    #1;
    e = sb_q.pop_front();
    if (e.chk_rd) check({e.name, " rdata"}, csr_rdata, e.rd);
    check({e.name, " hit"}, {31'd0, csr_hit}, {31'd0, e.hit});
    @(posedge clk_i);
    #1;
    csr_req   = 1'b0;
    csr_op    = OP_R;
    csr_wdata = '0;
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp_rd);
    csr_access(name, OP_R, addr, 32'h0, 1'b1, exp_rd, 1'b1);
  endtask

  vec_t vecs [23] = '{
    '{OP_R, 12'hB01, 32'hFFFF_FFFF, 32'h0,      1'b0},
    '{OP_W, 12'hB01, 32'h0000_0001, 32'h0,      1'b0},
    '{OP_R, 12'h321, 32'h0,         32'h0,      1'b0},
    '{OP_R, 12'hB81, 32'h0,         32'h0,      1'b0},
    '{OP_W, 12'hB1F, 32'hFFFF_FFFF, 32'h0,      1'b1},
    '{OP_R, 12'hB1F, 32'h0,         32'h0,      1'b1},
    '{OP_R, 12'hB9F, 32'h0,         32'h0,      1'b1},
    '{OP_R, 12'h323, 32'hFFFF_FFFF, 32'h6,      1'b1},
    '{OP_R, 12'h323, 32'h0,         32'h6,      1'b1},
    '{OP_W, 12'h324, 32'hFFFF_FFFF, 32'h0,      1'b1},
    '{OP_R, 12'h324, 32'h0,         32'hFFFF,   1'b1},
    '{OP_C, 12'h324, 32'h0000_FF00, 32'hFFFF,   1'b1},
    '{OP_R, 12'h324, 32'h0,         32'h00FF,   1'b1},
    '{OP_R, 12'hB0A, 32'h0,         32'h0,      1'b1},
    '{OP_R, 12'hB0B, 32'h0,         32'h0,      1'b1},
    '{OP_W, 12'h33F, 32'hFFFF_FFFF, 32'h0,      1'b1},
    '{OP_R, 12'h33F, 32'h0,         32'h0,      1'b1},
    '{OP_R, 12'h3A0, 32'h0,         32'h0,      1'b0},
    '{OP_R, 12'hB03, 32'h0,         32'd24,     1'b1},
    '{OP_R, 12'h322, 32'h0,         32'h0,      1'b1},
    '{OP_S, 12'hB83, 32'h3,         32'h0,      1'b1},
    '{OP_R, 12'hB83, 32'h0,         32'h3,      1'b1},
    '{OP_R, 12'hB03, 32'h0,         32'd24,     1'b1}
  };

  initial begin
    // Reset state: hit/rdata follow the request, everything reads zero.
    csr_access("rst_read_mcycle", OP_R, 12'hB00, 32'h0, 1'b1, 32'h0, 1'b1);
    csr_addr = 12'hB00;
    #1;
    check("idle_rdata", csr_rdata, 32'h0);
    check("idle_hit", {31'd0, csr_hit}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    repeat (10) @(posedge clk_i);
    rd("mcycle_after_10", 12'hB00, 32'd10);
    rd("minstret_reset", 12'hB02, 32'h0);
    rd("hpm3_reset", 12'hB03, 32'h0);

    // minstret carry into the high half, and high-half truncation.
    csr_access("wr_minstret", OP_W, 12'hB02, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
    csr_access("wr_minstreth", OP_W, 12'hB82, 32'h5A, 1'b1, 32'h0, 1'b1);
    @(negedge clk_i); instr_ret = 1'b1;
    @(negedge clk_i); instr_ret = 1'b0;
    rd("minstret_carry_lo", 12'hB02, 32'h0);
    rd("minstret_carry_hi", 12'hB82, 32'h5B);
    csr_access("wr_minstreth_wide", OP_W, 12'hB82, 32'h1FF, 1'b1, 32'h5B, 1'b1);
    rd("minstreth_trunc", 12'hB82, 32'hFF);

    // Event selection: multiple matches count once, unselected events ignored.
    csr_access("wr_event3", OP_W, 12'h323, 32'h6, 1'b1, 32'h0, 1'b1);
    rd("hpm3_before", 12'hB03, 32'h0);
    @(negedge clk_i); events = 16'h6;
    repeat (4) @(negedge clk_i);
    events = 16'h1;
    repeat (4) @(negedge clk_i);
    events = 16'h0;
    rd("hpm3_events", 12'hB03, 32'd4);

    // Inhibit mcycle/minstret; hpm3 keeps counting; inhibited counters writable.
    csr_access("set_inhibit", OP_S, 12'h320, 32'h5, 1'b1, 32'h0, 1'b1);
    csr_access("wr_mcycle_inh", OP_W, 12'hB00, 32'h1000, 1'b0, 32'h0, 1'b1);
    @(negedge clk_i); instr_ret = 1'b1; events = 16'h2;
    repeat (20) @(negedge clk_i);
    instr_ret = 1'b0; events = 16'h0;
    rd("mcycle_frozen", 12'hB00, 32'h1000);
    rd("minstret_frozen", 12'hB02, 32'h0);
    rd("minstreth_frozen", 12'hB82, 32'hFF);
    rd("hpm3_counts_inh", 12'hB03, 32'd24);
    csr_access("clr_inhibit", OP_C, 12'h320, 32'h5, 1'b1, 32'h5, 1'b1);
    rd("mcycle_old_inhibit", 12'hB00, 32'h1000);
    rd("mcycle_resumed", 12'hB00, 32'h1001);
    csr_access("wr_inhibit_all", OP_W, 12'h320, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
    rd("inhibit_mask", 12'h320, 32'h7FD);
    csr_access("wr_inhibit_zero", OP_W, 12'h320, 32'h0, 1'b1, 32'h7FD, 1'b1);

    // Write beats the same-cycle increment.
    csr_access("wr_mcycle_100", OP_W, 12'hB00, 32'h100, 1'b0, 32'h0, 1'b1);
    rd("mcycle_write_wins", 12'hB00, 32'h100);
    csr_access("wr_mcycle_max", OP_W, 12'hB00, 32'hFFFF_FFFF, 1'b1, 32'h101, 1'b1);
    rd("mcycleh_no_carry", 12'hB80, 32'h0);
    rd("mcycle_carry_lo", 12'hB00, 32'h0);
    rd("mcycle_carry_hi", 12'hB80, 32'h1);

    // Debug stop freezes every counter.
    @(negedge clk_i); debug_stop = 1'b1; instr_ret = 1'b1; events = 16'h6;
    csr_access("wr_mcycle_dbg", OP_W, 12'hB00, 32'h200, 1'b0, 32'h0, 1'b1);
    repeat (5) @(negedge clk_i);
    rd("mcycle_dbg", 12'hB00, 32'h200);
    rd("minstret_dbg", 12'hB02, 32'h0);
    rd("hpm3_dbg", 12'hB03, 32'd24);
    debug_stop = 1'b0; instr_ret = 1'b0; events = 16'h0;

    // Decode and field corner cases.
    for (int i = 0; i < 23; i++) begin
      csr_access($sformatf("vec%0d_%0h", i, vecs[i].addr), vecs[i].op, vecs[i].addr,
                 vecs[i].wdata, 1'b1, vecs[i].rd, vecs[i].hit);
    end

    // Full-width wrap to zero.
    csr_access("wr_hpm3h_max", OP_W, 12'hB83, 32'hFF, 1'b1, 32'h3, 1'b1);
    csr_access("wr_hpm3_max", OP_W, 12'hB03, 32'hFFFF_FFFF, 1'b1, 32'd24, 1'b1);
    @(negedge clk_i); events = 16'h2;
    @(negedge clk_i); events = 16'h0;
    rd("hpm3_wrap_lo", 12'hB03, 32'h0);
    rd("hpm3_wrap_hi", 12'hB83, 32'h0);

    // Reset in the middle of a pending write.
    @(negedge clk_i);
    csr_req = 1'b1; csr_op = OP_W; csr_addr = 12'hB03; csr_wdata = 32'h55;
    csr_access_reset_probe();
    rd("hpm3_after_rst", 12'hB03, 32'h0);
    rd("event3_after_rst", 12'h323, 32'h0);
    rd("inhibit_after_rst", 12'h320, 32'h0);
    rd("minstreth_after_rst", 12'hB82, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  task automatic csr_access_reset_probe();
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_rdata", csr_rdata, 32'h0);
    @(posedge clk_i);
    #1;
    csr_req = 1'b0; csr_op = OP_R; csr_wdata = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

endmodule
